change_dispenser: RTL and testbench

//  Payout end of the vending path: accepts a change request (Change_given strobe + Change_out amount)
//  and pays it out as physical coins, one at a time, over a handshake to the coin hopper.

---
 rtl/change_dispenser.sv | 239 +++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin payout engine: pays a requested amount as 50/20/10 coins, greedy and
// inventory-limited, one coin at a time over a valid/ack hopper handshake.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   Change_given, Change_out    1-cycle payout request and its amount
//   coin_ack                    hopper accepted the offered coin
//   refill_valid, refill_code   add one coin of the given denomination
//   fault_clr                   leave FAULT and clear the fault flags
//   coin_valid, coin_code       coin offered to the hopper
//   busy, done, overrun         payout in progress / finished / request dropped
//   shortfall, hopper_fault     fault causes, held while in FAULT
//   short_amt                   unpaid remainder while in FAULT
//   inv_10, inv_20, inv_50      per-denomination inventory counters
module change_dispenser #(
    parameter int CNT_W       = 6,
    parameter int INIT_10     = 20,
    parameter int INIT_20     = 20,
    parameter int INIT_50     = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Change_given,
    input  logic [7:0]       Change_out,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_code,
    input  logic             fault_clr,
    output logic             coin_valid,
    output logic [1:0]       coin_code,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             shortfall,
    output logic             hopper_fault,
    output logic [7:0]       short_amt,
    output logic [CNT_W-1:0] inv_10,
    output logic [CNT_W-1:0] inv_20,
    output logic [CNT_W-1:0] inv_50
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_FAULT
    } state_t;

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] C10 = 2'b00;
    localparam logic [1:0] C20 = 2'b01;
    localparam logic [1:0] C50 = 2'b10;

    state_t            state_q, state_d;
    logic [7:0]        rem_q, rem_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              short_q, short_d;
    logic              hfault_q, hfault_d;
    logic [7:0]        samt_q, samt_d;
    logic [CNT_W-1:0]  inv10_q, inv10_d;
    logic [CNT_W-1:0]  inv20_q, inv20_d;
    logic [CNT_W-1:0]  inv50_q, inv50_d;

    logic       sel_found;
    logic [1:0] sel_code;
    logic       ack_take;

    function automatic logic [7:0] coin_value(input logic [1:0] c);
        case (c)
            C10:     coin_value = 8'd10;
            C20:     coin_value = 8'd20;
            C50:     coin_value = 8'd50;
            default: coin_value = 8'd0;
        endcase
    endfunction

    // Simultaneous refill and payout of one denomination cancel out.
    function automatic logic [CNT_W-1:0] inv_next(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        if (inc && dec) begin
            inv_next = cur;
        end else if (inc) begin
            inv_next = (cur == CNT_MAX) ? cur : cur + 1'b1;
        end else if (dec) begin
            inv_next = cur - 1'b1;
        end else begin
            inv_next = cur;
        end
    endfunction

    // Largest coin that fits the remainder and is still in stock.
    always_comb begin
        sel_found = 1'b1;
        sel_code  = C10;
        if (rem_q >= 8'd50 && inv50_q != '0) begin
            sel_code = C50;
        end else if (rem_q >= 8'd20 && inv20_q != '0) begin
            sel_code = C20;
        end else if (rem_q >= 8'd10 && inv10_q != '0) begin
            sel_code = C10;
        end else begin
            sel_found = 1'b0;
        end
    end

    assign ack_take = (state_q == S_EJECT) && coin_ack;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            wait_q    <= '0;
            code_q    <= C10;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            short_q   <= 1'b0;
            hfault_q  <= 1'b0;
            samt_q    <= '0;
            inv10_q   <= CNT_W'(INIT_10);
            inv20_q   <= CNT_W'(INIT_20);
            inv50_q   <= CNT_W'(INIT_50);
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            short_q   <= short_d;
            hfault_q  <= hfault_d;
            samt_q    <= samt_d;
            inv10_q   <= inv10_d;
            inv20_q   <= inv20_d;
            inv50_q   <= inv50_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (Change_given) begin
                    rem_d   = Change_out;
                    state_d = (Change_out != 8'd0) ? S_SELECT : S_DONE;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    state_d = S_EJECT;
                    code_d  = sel_code;
                    wait_d  = '0;
                end else if (rem_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EJECT: begin
                if (coin_ack) begin
                    rem_d   = rem_q - coin_value(code_q);
                    state_d = S_SELECT;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state.
    always_comb begin
        valid_d   = (state_d == S_EJECT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        overrun_d = Change_given && (state_q != S_IDLE);
        // Fault cause is latched on entry and held until FAULT is left.
        short_d   = (state_d == S_FAULT)
                  && (short_q || state_q == S_SELECT);
        hfault_d  = (state_d == S_FAULT)
                  && (hfault_q || state_q == S_EJECT);
        samt_d    = (state_d == S_FAULT) ? rem_d : 8'd0;
        inv10_d   = inv_next(inv10_q,
                             refill_valid && refill_code == C10,
                             ack_take && code_q == C10);
        inv20_d   = inv_next(inv20_q,
                             refill_valid && refill_code == C20,
                             ack_take && code_q == C20);
        inv50_d   = inv_next(inv50_q,
                             refill_valid && refill_code == C50,
                             ack_take && code_q == C50);
    end

    assign coin_valid   = valid_q;
    assign coin_code    = code_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign shortfall    = short_q;
    assign hopper_fault = hfault_q;
    assign short_amt    = samt_q;
    assign inv_10       = inv10_q;
    assign inv_20       = inv20_q;
    assign inv_50       = inv50_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table, hand sequences
// for latency/timeout/overrun, and randomized payouts against a model.
module tb_change_dispenser;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, Change_given, coin_ack, refill_valid, fault_clr;
    logic [7:0] Change_out;
    logic [1:0] refill_code;

    logic       coin_valid, busy, done, overrun, shortfall, hopper_fault;
    logic [1:0] coin_code;
    logic [7:0] short_amt;
    logic [5:0] inv_10, inv_20, inv_50;

    logic       b_valid, b_busy, b_done, b_overrun, b_short, b_hf;
    logic [1:0] b_code;
    logic [7:0] b_samt;
    logic [5:0] b_inv10, b_inv20, b_inv50;

    change_dispenser dut (
        .CLK(CLK), .RESET(RESET), .Change_given(Change_given),
        .Change_out(Change_out), .coin_ack(coin_ack),
        .refill_valid(refill_valid), .refill_code(refill_code),
        .fault_clr(fault_clr), .coin_valid(coin_valid),
        .coin_code(coin_code), .busy(busy), .done(done),
        .overrun(overrun), .shortfall(shortfall),
        .hopper_fault(hopper_fault), .short_amt(short_amt),
        .inv_10(inv_10), .inv_20(inv_20), .inv_50(inv_50)
    );

    // Second instance with no 20/50 stock at reset.
    change_dispenser #(.INIT_20(0), .INIT_50(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .Change_given(Change_given),
        .Change_out(Change_out), .coin_ack(coin_ack),
        .refill_valid(refill_valid), .refill_code(refill_code),
        .fault_clr(fault_clr), .coin_valid(b_valid),
        .coin_code(b_code), .busy(b_busy), .done(b_done),
        .overrun(b_overrun), .shortfall(b_short),
        .hopper_fault(b_hf), .short_amt(b_samt),
        .inv_10(b_inv10), .inv_20(b_inv20), .inv_50(b_inv50)
    );

    bit use_b = 1'b0;
    logic       o_valid, o_busy, o_done, o_ovr, o_short, o_hf;
    logic [1:0] o_code;
    logic [7:0] o_samt;
    logic [5:0] o_i10, o_i20, o_i50;
    assign o_valid = use_b ? b_valid   : coin_valid;
    assign o_code  = use_b ? b_code    : coin_code;
    assign o_busy  = use_b ? b_busy    : busy;
    assign o_done  = use_b ? b_done    : done;
    assign o_ovr   = use_b ? b_overrun : overrun;
    assign o_short = use_b ? b_short   : shortfall;
    assign o_hf    = use_b ? b_hf      : hopper_fault;
    assign o_samt  = use_b ? b_samt    : short_amt;
    assign o_i10   = use_b ? b_inv10   : inv_10;
    assign o_i20   = use_b ? b_inv20   : inv_20;
    assign o_i50   = use_b ? b_inv50   : inv_50;

    int n_cmp = 0;
    int n_bad = 0;
    int m_inv[3];
    logic [1:0] got[$];
    logic [1:0] exp_codes[$];
    int exp_rem;
    int first_valid, last_ack, done_at;

    typedef struct {
        int amt; int ncoins; int first; int status; int sh;
        int i10; int i20; int i50;
    } vec_t;
    vec_t tbl[9];

    function automatic int val(input int c);
        case (c)
            0: return 10;
            1: return 20;
            2: return 50;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_inv(input string nm, input int a, input int b,
                           input int c);
        chk({nm, "_inv10"}, int'(o_i10), a);
        chk({nm, "_inv20"}, int'(o_i20), b);
        chk({nm, "_inv50"}, int'(o_i50), c);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        Change_given = 1'b0; Change_out = 8'd0; coin_ack = 1'b0;
        refill_valid = 1'b0; refill_code = 2'b00; fault_clr = 1'b0;
        step();
        step();
        RESET = 1'b0;
        m_inv = '{20, 20, 10};
    endtask

    // Greedy payout model: take as many of each coin as fit, largest first.
    task automatic model_pay(input int amt);
        int rem, n;
        exp_codes.delete();
        rem = amt;
        for (int c = 2; c >= 0; c--) begin
            n = rem / val(c);
            if (n > m_inv[c]) n = m_inv[c];
            rem -= n * val(c);
            m_inv[c] -= n;
            for (int i = 0; i < n; i++) exp_codes.push_back(2'(c));
        end
        exp_rem = rem;
    endtask

    task automatic model_refill(input int c);
        if (c != 3 && m_inv[c] < 63) m_inv[c]++;
    endtask

    task automatic refill(input int c);
        refill_valid = 1'b1;
        refill_code = 2'(c);
        step();
        refill_valid = 1'b0;
        model_refill(c);
    endtask

    // Runs the hopper side until done/fault; status 0 done, 1 short, 2 hopper.
    task automatic collect(input int max_dly, input bit tie, input bit ref20,
                           output int status, output int sh);
        int w, dly;
        status = 3; sh = 0; w = 0;
        dly = $urandom_range(0, max_dly);
        first_valid = -1; last_ack = -1; done_at = -1;
        for (int s = 0; s < 400; s++) begin
            refill_valid = 1'b0;
            if (o_done) begin status = 0; done_at = s; break; end
            if (o_short) begin status = 1; sh = int'(o_samt); break; end
            if (o_hf) begin status = 2; break; end
            if (o_valid) begin
                if (first_valid < 0) first_valid = s;
                if (tie || w >= dly) begin
                    coin_ack = 1'b1;
                    got.push_back(o_code);
                    last_ack = s;
                    w = 0;
                    dly = $urandom_range(0, max_dly);
                    if (ref20 && o_code == 2'b01) begin
                        refill_valid = 1'b1;
                        refill_code = 2'b01;
                    end
                end else begin
                    coin_ack = 1'b0;
                    w++;
                end
            end else begin
                coin_ack = tie;
            end
            step();
        end
        coin_ack = 1'b0;
        refill_valid = 1'b0;
        if (status == 3) chk("payout_timeout", 1, 0);
    endtask

    task automatic payout(input int amt, input int max_dly, input bit tie,
                          output int status, output int sh);
        got.delete();
        Change_given = 1'b1;
        Change_out = 8'(amt);
        coin_ack = tie;
        step();
        Change_given = 1'b0;
        chk("busy_after_req", int'(o_busy), 1);
        collect(max_dly, tie, 1'b0, status, sh);
    endtask

    task automatic post(input int status);
        if (status == 0) begin
            step();
            chk("done_one_cycle", int'(o_done), 0);
            chk("busy_after_done", int'(o_busy), 0);
        end else if (status == 1 || status == 2) begin
            fault_clr = 1'b1;
            step();
            fault_clr = 1'b0;
            chk("clr_busy", int'(o_busy), 0);
            chk("clr_short", int'(o_short), 0);
            chk("clr_hf", int'(o_hf), 0);
            chk("clr_samt", int'(o_samt), 0);
        end
    endtask

    task automatic cmp_codes(input string nm);
        int mis;
        mis = 0;
        chk({nm, "_ncoins"}, got.size(), exp_codes.size());
        for (int i = 0; i < got.size() && i < exp_codes.size(); i++)
            if (got[i] != exp_codes[i]) mis++;
        chk({nm, "_seq_err"}, mis, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, sh, amt, cnt;

        tbl[0] = '{80,  3, 2, 0, 0, 19, 19, 9};
        tbl[1] = '{0,   0, 0, 0, 0, 19, 19, 9};
        tbl[2] = '{15,  1, 0, 1, 5, 18, 19, 9};
        tbl[3] = '{255, 5, 2, 1, 5, 18, 19, 4};
        tbl[4] = '{130, 4, 2, 0, 0, 17, 18, 2};
        tbl[5] = '{7,   0, 0, 1, 7, 17, 18, 2};
        tbl[6] = '{200, 7, 2, 0, 0, 17, 13, 0};
        tbl[7] = '{60,  3, 1, 0, 0, 17, 10, 0};
        tbl[8] = '{45,  2, 1, 1, 5, 17, 8,  0};

        // T1: reset state
        do_reset();
        chk_inv("rst", 20, 20, 10);
        chk("rst_valid", int'(coin_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_short", int'(shortfall), 0);
        chk("rst_hf", int'(hopper_fault), 0);
        chk("rst_samt", int'(short_amt), 0);
        chk("rst_code", int'(coin_code), 0);

        // Vector table, applied back to back from reset
        do_reset();
        foreach (tbl[i]) begin
            payout(tbl[i].amt, 1, 1'b0, st, sh);
            chk($sformatf("tbl%0d_ncoins", i), got.size(), tbl[i].ncoins);
            if (tbl[i].ncoins > 0)
                chk($sformatf("tbl%0d_first", i), int'(got[0]),
                    tbl[i].first);
            chk($sformatf("tbl%0d_status", i), st, tbl[i].status);
            chk($sformatf("tbl%0d_samt", i), sh, tbl[i].sh);
            post(st);
            chk_inv($sformatf("tbl%0d", i), tbl[i].i10, tbl[i].i20,
                    tbl[i].i50);
        end

        // T2: 80 with ack tied high, latency checks
        do_reset();
        payout(80, 0, 1'b1, st, sh);
        exp_codes = '{2'b10, 2'b01, 2'b00};
        cmp_codes("t2");
        chk("t2_status", st, 0);
        chk("t2_first_valid", first_valid, 1);
        chk("t2_done_lat", done_at - last_ack, 2);
        post(st);
        chk_inv("t2", 19, 19, 9);

        // T3: only 10s in stock
        do_reset();
        use_b = 1'b1;
        payout(40, 2, 1'b0, st, sh);
        exp_codes = '{2'b00, 2'b00, 2'b00, 2'b00};
        cmp_codes("t3");
        chk("t3_status", st, 0);
        post(st);
        chk_inv("t3", 16, 0, 0);
        use_b = 1'b0;

        // T5: hopper never acks
        do_reset();
        Change_given = 1'b1; Change_out = 8'd20;
        step();
        Change_given = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && !hopper_fault; i++) begin
            if (coin_valid) cnt++;
            step();
        end
        chk("t5_valid_cycles", cnt, 15);
        chk("t5_hf", int'(hopper_fault), 1);
        chk("t5_short", int'(shortfall), 0);
        chk("t5_samt", int'(short_amt), 20);
        chk("t5_valid_off", int'(coin_valid), 0);
        step();
        chk("t5_hf_hold", int'(hopper_fault), 1);
        chk("t5_busy_hold", int'(busy), 1);
        chk_inv("t5", 20, 20, 10);
        post(2);

        // T6: overrun mid-payout, refill of 20 coincident with 20 ack
        do_reset();
        got.delete();
        Change_given = 1'b1; Change_out = 8'd80;
        step();
        Change_given = 1'b0;
        step();
        chk("t6_valid", int'(coin_valid), 1);
        chk("t6_code", int'(coin_code), 2);
        Change_given = 1'b1; Change_out = 8'd30;
        step();
        Change_given = 1'b0;
        chk("t6_overrun", int'(overrun), 1);
        step();
        chk("t6_overrun_end", int'(overrun), 0);
        collect(3, 1'b0, 1'b1, st, sh);
        exp_codes = '{2'b10, 2'b01, 2'b00};
        cmp_codes("t6");
        chk("t6_status", st, 0);
        post(st);
        chk_inv("t6", 19, 20, 9);

        // Refill saturation and ignored code
        do_reset();
        for (int i = 0; i < 60; i++) refill(2);
        for (int i = 0; i < 3; i++) refill(3);
        chk_inv("sat", m_inv[0], m_inv[1], m_inv[2]);
        chk("sat_max", int'(inv_50), 63);

        // Randomized payouts against the model
        for (int t = 0; t < 40; t++) begin
            cnt = $urandom_range(0, 2);
            for (int r = 0; r < cnt; r++) refill($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) amt = $urandom_range(0, 255);
            else amt = $urandom_range(0, 25) * 10;
            model_pay(amt);
            payout(amt, 4, 1'b0, st, sh);
            cmp_codes($sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d_status", t), st, exp_rem == 0 ? 0 : 1);
            chk($sformatf("rnd%0d_samt", t), sh, exp_rem);
            post(st);
            chk_inv($sformatf("rnd%0d", t), m_inv[0], m_inv[1], m_inv[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
